// File: rtl/pll_lock_sequencer.sv
// Power-up sequencer for the iCE40 PLL: reset hold, lock wait, lock qualification, run, fault.
// Optional fallback to the 12 MHz pass-through on fault: define PLL_BYPASS_FALLBACK_EN.
module pll_lock_sequencer #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 1200,
   parameter int STABLE_CYCLES = 64,
   parameter int MAX_RETRY     = 3,
   parameter int RETRY_W       = 2,
   parameter int CNT_W         = 16
) (
   input  logic               REFERENCECLK,
   input  logic               RESET,
   input  logic               PLL_LOCK,
   input  logic               RESTART,
   output logic               PLL_RESETB,
   output logic               PLL_BYPASS,
   output logic               SYS_RESET_N,
   output logic               PLL_READY,
   output logic               FAULT,
   output logic [RETRY_W-1:0] RETRY_CNT,
   output logic [2:0]         STATE
);

   typedef enum logic [2:0] {
      S_RST_HOLD  = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4,
      S_BYPASS    = 3'd5
   } state_t;

`ifdef PLL_BYPASS_FALLBACK_EN
   localparam state_t FAIL_STATE = S_BYPASS;
`else
   localparam state_t FAIL_STATE = S_FAULT;
`endif

   localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_FULL  = CNT_W'(STABLE_CYCLES);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [RETRY_W-1:0] retry_d;
   logic [1:0]         sync_q;
   logic               lock_s;
   logic               resetb_d, bypass_d, sys_d, ready_d, fault_d;

   assign lock_s  = sync_q[1];
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign STATE   = state_q;

   always_ff @(posedge REFERENCECLK or negedge RESET) begin
      if (!RESET) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], PLL_LOCK};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      retry_d = RETRY_CNT;
      if (RESTART) begin
         state_d = S_RST_HOLD;
         retry_d = '0;
      end else begin
         case (state_q)
            S_RST_HOLD: begin
               if (cnt_q == RESET_LAST) state_d = S_WAIT_LOCK;
               else                     cnt_d   = cnt_inc;
            end
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = S_STABLE;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  if (RETRY_CNT == RETRY_MAX) begin
                     state_d = FAIL_STATE;
                  end else begin
                     retry_d = RETRY_CNT + RETRY_W'(1);
                     state_d = S_RST_HOLD;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_STABLE: begin
               if (!lock_s) begin
                  state_d = S_WAIT_LOCK;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = S_RUN;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_RUN: begin
               if (!lock_s) state_d = S_RST_HOLD;
            end
            S_FAULT: begin
               state_d = S_FAULT;
            end
`ifdef PLL_BYPASS_FALLBACK_EN
            // Counter saturates at STABLE_FULL to time the system-reset release.
            S_BYPASS: begin
               cnt_d = (cnt_q == STABLE_FULL) ? cnt_q : cnt_inc;
            end
`endif
            default: state_d = S_RST_HOLD;
         endcase
      end

      resetb_d = (state_d == S_WAIT_LOCK) || (state_d == S_STABLE) || (state_d == S_RUN);
      ready_d  = (state_d == S_RUN);
`ifdef PLL_BYPASS_FALLBACK_EN
      bypass_d = (state_d == S_BYPASS);
      fault_d  = (state_d == S_FAULT) || (state_d == S_BYPASS);
      sys_d    = (state_d == S_RUN) || ((state_d == S_BYPASS) && (cnt_d == STABLE_FULL));
`else
      bypass_d = 1'b0;
      fault_d  = (state_d == S_FAULT);
      sys_d    = (state_d == S_RUN);
`endif
   end

   // Outputs are decoded from the next state so they move on the same edge as STATE.
   always_ff @(posedge REFERENCECLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= S_RST_HOLD;
         cnt_q       <= '0;
         RETRY_CNT   <= '0;
         PLL_RESETB  <= 1'b0;
         PLL_BYPASS  <= 1'b0;
         SYS_RESET_N <= 1'b0;
         PLL_READY   <= 1'b0;
         FAULT       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         RETRY_CNT   <= retry_d;
         PLL_RESETB  <= resetb_d;
         PLL_BYPASS  <= bypass_d;
         SYS_RESET_N <= sys_d;
         PLL_READY   <= ready_d;
         FAULT       <= fault_d;
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed timing points plus randomized lock/restart/reset traffic
// checked against an elapsed-time reference model.
module tb_pll_lock_sequencer;

   localparam int RESET_CYCLES  = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRY     = 2;

   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_STAB = 2;
   localparam int P_RUN  = 3;
   localparam int P_FLT  = 4;
   localparam int P_BYP  = 5;

   logic       clk = 1'b0;
   bit         clk_en = 1'b1;
   logic       rst_n;
   logic       pll_lock;
   logic       restart;
   logic       pll_resetb, pll_bypass, sys_reset_n, pll_ready, fault;
   logic [1:0] retry_cnt;
   logic [2:0] state;
   logic [9:0] outs;

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;

   logic [9:0] exp_q[$];
   bit         hist[$];
   int         m_phase, m_start, m_edge, m_retry, m_el;
   bit         m_ls;

   pll_lock_sequencer #(
      .RESET_CYCLES(RESET_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRY(MAX_RETRY), .RETRY_W(2), .CNT_W(16)
   ) dut (
      .REFERENCECLK(clk), .RESET(rst_n), .PLL_LOCK(pll_lock), .RESTART(restart),
      .PLL_RESETB(pll_resetb), .PLL_BYPASS(pll_bypass), .SYS_RESET_N(sys_reset_n),
      .PLL_READY(pll_ready), .FAULT(fault), .RETRY_CNT(retry_cnt), .STATE(state)
   );

   assign outs = {state, retry_cnt, pll_resetb, pll_bypass, sys_reset_n, pll_ready, fault};

   always #5 if (clk_en) clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   // Reference model: phases timed by edges elapsed since phase entry; lock seen two edges late.
   task automatic enter(input int p);
      m_phase = p;
      m_start = m_edge;
   endtask

   function automatic logic [9:0] model_outs();
      logic rb, bp, sy, rd, ft;
      rb = (m_phase == P_WAIT) || (m_phase == P_STAB) || (m_phase == P_RUN);
      bp = (m_phase == P_BYP);
      sy = (m_phase == P_RUN) || ((m_phase == P_BYP) && ((m_edge - m_start) >= STABLE_CYCLES));
      rd = (m_phase == P_RUN);
      ft = (m_phase == P_FLT) || (m_phase == P_BYP);
      return {3'(m_phase), 2'(m_retry), rb, bp, sy, rd, ft};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = P_RST;
         m_edge  = 0;
         m_start = 0;
         m_retry = 0;
         hist.delete();
         hist.push_back(1'b0);
         hist.push_back(1'b0);
         exp_q.delete();
      end else begin
         m_edge++;
         m_ls = hist[0];
         hist.push_back(pll_lock);
         hist.delete(0);
         m_el = m_edge - m_start;
         if (restart) begin
            enter(P_RST);
            m_retry = 0;
         end else begin
            case (m_phase)
               P_RST:  if (m_el == RESET_CYCLES) enter(P_WAIT);
               P_WAIT: begin
                  if (m_ls) enter(P_STAB);
                  else if (m_el == LOCK_TIMEOUT) begin
                     if (m_retry == MAX_RETRY) begin
`ifdef PLL_BYPASS_FALLBACK_EN
                        enter(P_BYP);
`else
                        enter(P_FLT);
`endif
                     end else begin
                        m_retry++;
                        enter(P_RST);
                     end
                  end
               end
               P_STAB: begin
                  if (!m_ls) enter(P_WAIT);
                  else if (m_el == STABLE_CYCLES) begin
                     enter(P_RUN);
                     m_retry = 0;
                  end
               end
               P_RUN:  if (!m_ls) enter(P_RST);
               default: ;
            endcase
         end
         exp_q.push_back(model_outs());
      end
   end

   always @(negedge clk) begin
      logic [9:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("model_outs", 32'(outs), 32'(e));
      end
   end

   task automatic wait_edge(input int n);
      int guard;
      guard = 0;
      while (edge_n < n && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      check("edge_reached", 32'(edge_n), 32'(n));
   endtask

   initial begin
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      restart  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_vals", 32'(outs), 32'd0);
      #1 rst_n = 1'b1;

      // Nominal acquisition, lock first sampled at edge 10
      wait_edge(3);
      check("resetb_hold", 32'(pll_resetb), 32'd0);
      wait_edge(4);
      check("resetb_rel", 32'(pll_resetb), 32'd1);
      check("st_wait", 32'(state), 32'd1);
      wait_edge(9);
      pll_lock = 1'b1;
      wait_edge(11);
      check("st_wait_11", 32'(state), 32'd1);
      wait_edge(12);
      check("st_stable_12", 32'(state), 32'd2);
      wait_edge(19);
      check("sys_19", 32'(sys_reset_n), 32'd0);
      wait_edge(20);
      check("sys_20", 32'(sys_reset_n), 32'd1);
      check("ready_20", 32'(pll_ready), 32'd1);
      check("retry_20", 32'(retry_cnt), 32'd0);

      // Lock loss in RUN, first sampled at edge 26
      wait_edge(25);
      pll_lock = 1'b0;
      wait_edge(27);
      check("st_run_27", 32'(state), 32'd3);
      wait_edge(28);
      check("st_rst_28", 32'(state), 32'd0);
      check("sys_28", 32'(sys_reset_n), 32'd0);
      check("ready_28", 32'(pll_ready), 32'd0);

      // Re-acquire with a one-cycle glitch during STABLE
      wait_edge(32);
      check("st_wait_32", 32'(state), 32'd1);
      wait_edge(33);
      pll_lock = 1'b1;
      wait_edge(36);
      check("st_stable_36", 32'(state), 32'd2);
      wait_edge(40);
      pll_lock = 1'b0;
      wait_edge(41);
      pll_lock = 1'b1;
      wait_edge(43);
      check("glitch_st", 32'(state), 32'd1);
      check("glitch_retry", 32'(retry_cnt), 32'd0);
      wait_edge(44);
      check("st_stable_44", 32'(state), 32'd2);
      wait_edge(51);
      check("st_stable_51", 32'(state), 32'd2);
      wait_edge(52);
      check("st_run_52", 32'(state), 32'd3);
      check("sys_52", 32'(sys_reset_n), 32'd1);

      // No lock from a fresh reset
      wait_edge(55);
      #1 rst_n = 1'b0;
      pll_lock = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_running", 32'(outs), 32'd0);
      #1 rst_n = 1'b1;
      wait_edge(23);
      check("retry_23", 32'(retry_cnt), 32'd0);
      wait_edge(24);
      check("retry_24", 32'(retry_cnt), 32'd1);
      check("st_rst_24", 32'(state), 32'd0);
      wait_edge(48);
      check("retry_48", 32'(retry_cnt), 32'd2);
      wait_edge(71);
      check("st_wait_71", 32'(state), 32'd1);
      wait_edge(72);
      check("fault_72", 32'(fault), 32'd1);
      check("resetb_72", 32'(pll_resetb), 32'd0);
      check("sys_72", 32'(sys_reset_n), 32'd0);
`ifdef PLL_BYPASS_FALLBACK_EN
      check("st_byp_72", 32'(state), 32'd5);
      check("bypass_72", 32'(pll_bypass), 32'd1);
      wait_edge(79);
      check("sys_79", 32'(sys_reset_n), 32'd0);
      wait_edge(80);
      check("sys_80", 32'(sys_reset_n), 32'd1);
`else
      check("st_fault_72", 32'(state), 32'd4);
      check("bypass_72", 32'(pll_bypass), 32'd0);
      wait_edge(80);
      check("fault_hold_80", 32'(state), 32'd4);
`endif

      // Restart pulse out of the fault state
      wait_edge(85);
      restart = 1'b1;
      wait_edge(86);
      restart = 1'b0;
      check("restart_st", 32'(state), 32'd0);
      check("restart_fault", 32'(fault), 32'd0);
      check("restart_retry", 32'(retry_cnt), 32'd0);
      check("restart_bypass", 32'(pll_bypass), 32'd0);

      // Async reset mid-WAIT_LOCK with the clock stopped
      wait_edge(95);
      check("pre_async_st", 32'(state), 32'd1);
      clk_en = 1'b0;
      #7 rst_n = 1'b0;
      #3 check("async_reset", 32'(outs), 32'd0);
      #10 rst_n = 1'b1;
      #4 clk_en = 1'b1;

      // Randomized traffic against the reference model
      for (int seg = 0; seg < 60; seg++) begin
         int mode;
         int len;
         mode = $urandom_range(0, 9);
         @(negedge clk);
         if (mode <= 3) begin
            pll_lock = 1'b1;
            len = $urandom_range(10, 120);
            repeat (len) @(negedge clk);
         end else if (mode <= 5) begin
            pll_lock = 1'b0;
            len = $urandom_range(1, 3);
            repeat (len) @(negedge clk);
            pll_lock = 1'b1;
         end else if (mode <= 7) begin
            pll_lock = 1'b0;
            len = $urandom_range(20, 200);
            repeat (len) @(negedge clk);
         end else if (mode == 8) begin
            restart = 1'b1;
            @(negedge clk);
            restart = 1'b0;
         end else begin
            #1 rst_n = 1'b0;
            #3 rst_n = 1'b1;
         end
      end
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
